// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle between the two write-back sources (ALU, decoder) and
// the arbiter that drives the register-file write port.
//   alu_valid/alu_ready/alu_data/alu_addr : ALU write-back request handshake
//   dec_valid/dec_ready/dec_data/dec_addr : decoder write-back request handshake
//   indata_sel/indata/wr_addr/wr_en       : registered register-file write port
// modport master : the sources / register-file side
// modport slave  : the arbiter
interface wb_port_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [DATA_W-1:0] alu_data;
  logic [ADDR_W-1:0] alu_addr;
  logic              dec_valid;
  logic              dec_ready;
  logic [DATA_W-1:0] dec_data;
  logic [ADDR_W-1:0] dec_addr;
  logic              indata_sel;
  logic [DATA_W-1:0] indata;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;

  modport master (
    output alu_valid, alu_data, alu_addr,
    output dec_valid, dec_data, dec_addr,
    input  alu_ready, dec_ready,
    input  indata_sel, indata, wr_addr, wr_en
  );

  modport slave (
    input  alu_valid, alu_data, alu_addr,
    input  dec_valid, dec_data, dec_addr,
    output alu_ready, dec_ready,
    output indata_sel, indata, wr_addr, wr_en
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between the
// ALU result and the decoder immediate path. Each source owns a one-entry
// holding buffer; write data/address/enable/select are registered.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : wb_port_arbiter_if.slave (source handshakes + register-file write port)
module wb_port_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  wb_port_arbiter_if.slave bus
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_DEC = 1'b1
  } src_e;

  logic              r_alu_full;
  logic [DATA_W-1:0] r_alu_data;
  logic [ADDR_W-1:0] r_alu_addr;
  logic              r_dec_full;
  logic [DATA_W-1:0] r_dec_data;
  logic [ADDR_W-1:0] r_dec_addr;
  src_e              r_last_grant;

  logic              r_indata_sel;
  logic [DATA_W-1:0] r_indata;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_wr_en;

  logic w_grant_alu;
  logic w_grant_dec;
  logic w_alu_take;
  logic w_dec_take;

  // On a tie the source that did not win last time is served.
  assign w_grant_alu = r_alu_full & (~r_dec_full | (r_last_grant == SRC_DEC));
  assign w_grant_dec = r_dec_full & (~r_alu_full | (r_last_grant == SRC_ALU));

  // A buffer being drained this cycle can accept a new entry on the same edge.
  assign bus.alu_ready = ~r_alu_full | w_grant_alu;
  assign bus.dec_ready = ~r_dec_full | w_grant_dec;

  assign w_alu_take = bus.alu_valid & bus.alu_ready;
  assign w_dec_take = bus.dec_valid & bus.dec_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_full   <= 1'b0;
      r_alu_data   <= '0;
      r_alu_addr   <= '0;
      r_dec_full   <= 1'b0;
      r_dec_data   <= '0;
      r_dec_addr   <= '0;
      r_last_grant <= SRC_DEC;
      r_indata_sel <= 1'b0;
      r_indata     <= '0;
      r_wr_addr    <= '0;
      r_wr_en      <= 1'b0;
    end else begin
      if (w_alu_take) begin
        r_alu_full <= 1'b1;
        r_alu_data <= bus.alu_data;
        r_alu_addr <= bus.alu_addr;
      end else if (w_grant_alu) begin
        r_alu_full <= 1'b0;
      end

      if (w_dec_take) begin
        r_dec_full <= 1'b1;
        r_dec_data <= bus.dec_data;
        r_dec_addr <= bus.dec_addr;
      end else if (w_grant_dec) begin
        r_dec_full <= 1'b0;
      end

      // Register 0 still consumes its grant slot; only the write strobe is suppressed.
      if (w_grant_alu) begin
        r_last_grant <= SRC_ALU;
        r_indata_sel <= 1'b0;
        r_indata     <= r_alu_data;
        r_wr_addr    <= r_alu_addr;
        r_wr_en      <= |r_alu_addr;
      end else if (w_grant_dec) begin
        r_last_grant <= SRC_DEC;
        r_indata_sel <= 1'b1;
        r_indata     <= r_dec_data;
        r_wr_addr    <= r_dec_addr;
        r_wr_en      <= |r_dec_addr;
      end else begin
        r_wr_en      <= 1'b0;
      end
    end
  end

  assign bus.indata_sel = r_indata_sel;
  assign bus.indata     = r_indata;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_en      = r_wr_en;

endmodule
